// File: rtl/t_ff_toggle_arbiter_pkg.sv
// rtl/t_ff_toggle_arbiter_pkg.sv - shared types and round-robin helper for the toggle arbiter
// Purpose: FSM state encoding, index widths and the rr_pick search function.
package t_ff_toggle_arbiter_pkg;

   localparam int MAX_REQ = 16;
   localparam int IDX_W   = 4;

   localparam logic [1:0] ENC_IDLE = 2'd0;
   localparam logic [1:0] ENC_RUN  = 2'd1;
   localparam logic [1:0] ENC_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ENC_IDLE,
      RUN  = ENC_RUN,
      DONE = ENC_DONE
   } state_t;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } pick_t;

   // First set bit of req searching upward from ptr, wrapping at nreq.
   // The loop runs from the far end so the closest candidate to ptr is
   // written last and wins.
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                     input logic [IDX_W-1:0]   ptr,
                                     input int                 nreq);
      pick_t          p;
      logic [IDX_W:0] s;
      p = '0;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         if (k < nreq) begin
            s = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (s >= (IDX_W + 1)'(nreq)) begin
               s = s - (IDX_W + 1)'(nreq);
            end
            if (req[s[IDX_W-1:0]]) begin
               p.valid = 1'b1;
               p.idx   = s[IDX_W-1:0];
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/t_ff_toggle_arbiter_t_ff.sv
// rtl/t_ff_toggle_arbiter_t_ff.sv - shared T flip-flop cell
// Purpose: toggles q on a rising clk edge when both en and t are high.
// Ports: clk, rst (async active-high), en, t, q.
module t_ff_toggle_arbiter_t_ff (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic t,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= 1'b0;
      end else if (en && t) begin
         q <= ~q;
      end
   end

endmodule

// File: rtl/t_ff_toggle_arbiter.sv
// rtl/t_ff_toggle_arbiter.sv - round-robin sequencer sharing one t_ff among NREQ requesters
// Purpose: grants the t_ff to one requester at a time for a burst of toggles.
// Ports: clk, reset (async active-high), req[NREQ], cnt_in[NREQ*CW], abort,
//        gnt[NREQ] (one-hot owner), done[NREQ] (completion pulse), aborted,
//        busy, toggles_left[CW], q (shared cell output).
module t_ff_toggle_arbiter
   import t_ff_toggle_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int CW   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*CW-1:0]   cnt_in,
   input  logic                 abort,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      done,
   output logic                 aborted,
   output logic                 busy,
   output logic [CW-1:0]        toggles_left,
   output logic                 q
);

   state_t           state, state_d;
   logic [IDX_W-1:0] owner, owner_d;
   logic [IDX_W-1:0] ptr, ptr_d;
   logic [CW-1:0]    tl_d;
   logic             aborted_d;
   logic             cell_en;
   logic [CW-1:0]    cnt_sel;
   pick_t            pick;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         owner        <= '0;
         ptr          <= '0;
         toggles_left <= '0;
         aborted      <= 1'b0;
      end else begin
         state        <= state_d;
         owner        <= owner_d;
         ptr          <= ptr_d;
         toggles_left <= tl_d;
         aborted      <= aborted_d;
      end
   end

   always_comb begin
      state_d   = state;
      owner_d   = owner;
      ptr_d     = ptr;
      tl_d      = toggles_left;
      aborted_d = aborted;
      cell_en   = 1'b0;
      pick      = rr_pick(MAX_REQ'(req), ptr, NREQ);
      cnt_sel   = cnt_in[int'(pick.idx) * CW +: CW];

      case (state)
         IDLE: begin
            aborted_d = 1'b0;
            if (pick.valid) begin
               owner_d = pick.idx;
               tl_d    = cnt_sel;
               // A zero-length burst goes straight to DONE so the counter
               // can never be decremented below zero.
               state_d = (cnt_sel != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (abort) begin
               // Cell stays disabled this cycle; remaining count is frozen.
               aborted_d = 1'b1;
               state_d   = DONE;
            end else begin
               cell_en = 1'b1;
               tl_d    = toggles_left - 1'b1;
               if (toggles_left == CW'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            ptr_d     = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;
            aborted_d = 1'b0;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);
   assign gnt  = busy ? (NREQ'(1) << owner) : '0;
   assign done = (state == DONE) ? (NREQ'(1) << owner) : '0;

   t_ff_toggle_arbiter_t_ff u_cell (
      .clk (clk),
      .rst (reset),
      .en  (cell_en),
      .t   (cell_en),
      .q   (q)
   );

endmodule

// File: tb/tb_t_ff_toggle_arbiter.sv
// tb/tb_t_ff_toggle_arbiter.sv - directed vector bench for t_ff_toggle_arbiter
module tb_t_ff_toggle_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] cnt_in = '0;
   logic        abort = 1'b0;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic        aborted;
   logic        busy;
   logic [7:0]  toggles_left;
   logic        q;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [31:0] cnt;
      logic        abort;
      logic [3:0]  gnt;
      logic [3:0]  done;
      logic        ab;
      logic        busy;
      logic [7:0]  tl;
      logic        q;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   t_ff_toggle_arbiter #(.NREQ(4), .CW(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .cnt_in       (cnt_in),
      .abort        (abort),
      .gnt          (gnt),
      .done         (done),
      .aborted      (aborted),
      .busy         (busy),
      .toggles_left (toggles_left),
      .q            (q)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] c,
                      input logic a, input logic [3:0] g, input logic [3:0] d,
                      input logic ab, input logic b, input logic [7:0] tl,
                      input logic qq);
      vec_t v;
      v.rst = r; v.req = rq; v.cnt = c; v.abort = a;
      v.gnt = g; v.done = d; v.ab = ab; v.busy = b; v.tl = tl; v.q = qq;
      vecs.push_back(v);
   endtask

   task automatic check_all(input string tag, input logic [3:0] g, input logic [3:0] d,
                            input logic ab, input logic b, input logic [7:0] tl,
                            input logic qq);
      check({tag, ".gnt"}, int'(gnt), int'(g));
      check({tag, ".done"}, int'(done), int'(d));
      check({tag, ".aborted"}, int'(aborted), int'(ab));
      check({tag, ".busy"}, int'(busy), int'(b));
      check({tag, ".toggles_left"}, int'(toggles_left), int'(tl));
      check({tag, ".q"}, int'(q), int'(qq));
   endtask

   initial begin
      // reset held with all requesting
      add(1, 4'b1111, 32'h01010101, 0, 4'h0, 4'h0, 0, 0, 8'd0, 0);
      add(1, 4'b1111, 32'h01010101, 0, 4'h0, 4'h0, 0, 0, 8'd0, 0);
      // all requesting, count 1 each: rotation 0,1,2,3,0
      add(0, 4'b1111, 32'h01010101, 0, 4'h1, 4'h0, 0, 1, 8'd1, 0);
      add(0, 4'b1111, 32'h01010101, 0, 4'h1, 4'h1, 0, 1, 8'd0, 1);
      add(0, 4'b1111, 32'h01010101, 0, 4'h0, 4'h0, 0, 0, 8'd0, 1);
      add(0, 4'b1111, 32'h01010101, 0, 4'h2, 4'h0, 0, 1, 8'd1, 1);
      add(0, 4'b1111, 32'h01010101, 0, 4'h2, 4'h2, 0, 1, 8'd0, 0);
      add(0, 4'b1111, 32'h01010101, 0, 4'h0, 4'h0, 0, 0, 8'd0, 0);
      add(0, 4'b1111, 32'h01010101, 0, 4'h4, 4'h0, 0, 1, 8'd1, 0);
      add(0, 4'b1111, 32'h01010101, 0, 4'h4, 4'h4, 0, 1, 8'd0, 1);
      add(0, 4'b1111, 32'h01010101, 0, 4'h0, 4'h0, 0, 0, 8'd0, 1);
      add(0, 4'b1111, 32'h01010101, 0, 4'h8, 4'h0, 0, 1, 8'd1, 1);
      add(0, 4'b1111, 32'h01010101, 0, 4'h8, 4'h8, 0, 1, 8'd0, 0);
      add(0, 4'b1111, 32'h01010101, 0, 4'h0, 4'h0, 0, 0, 8'd0, 0);
      add(0, 4'b1111, 32'h01010101, 0, 4'h1, 4'h0, 0, 1, 8'd1, 0);
      add(0, 4'b1111, 32'h01010101, 0, 4'h1, 4'h1, 0, 1, 8'd0, 1);
      add(0, 4'b0000, 32'h00000000, 0, 4'h0, 4'h0, 0, 0, 8'd0, 1);
      // reset between sections
      add(1, 4'b0000, 32'h00000000, 0, 4'h0, 4'h0, 0, 0, 8'd0, 0);
      // single burst of 3 on requester 0
      add(0, 4'b0001, 32'h00000003, 0, 4'h1, 4'h0, 0, 1, 8'd3, 0);
      add(0, 4'b0001, 32'h00000003, 0, 4'h1, 4'h0, 0, 1, 8'd2, 1);
      add(0, 4'b0001, 32'h00000003, 0, 4'h1, 4'h0, 0, 1, 8'd1, 0);
      add(0, 4'b0001, 32'h00000003, 0, 4'h1, 4'h1, 0, 1, 8'd0, 1);
      add(0, 4'b0000, 32'h00000000, 0, 4'h0, 4'h0, 0, 0, 8'd0, 1);
      // zero count on requester 2: DONE only, q unchanged
      add(0, 4'b0100, 32'h00000000, 0, 4'h4, 4'h4, 0, 1, 8'd0, 1);
      add(0, 4'b0000, 32'h00000000, 0, 4'h0, 4'h0, 0, 0, 8'd0, 1);
      // ptr now 3: req 1010 must pick 3 (count 0), not 1
      add(0, 4'b1010, 32'h00000A00, 0, 4'h8, 4'h8, 0, 1, 8'd0, 1);
      add(0, 4'b0010, 32'h00000A00, 0, 4'h0, 4'h0, 0, 0, 8'd0, 1);
      // reset, then abort test on requester 1, count 10
      add(1, 4'b0000, 32'h00000000, 0, 4'h0, 4'h0, 0, 0, 8'd0, 0);
      add(0, 4'b0010, 32'h00000A00, 0, 4'h2, 4'h0, 0, 1, 8'd10, 0);
      add(0, 4'b0010, 32'h00000A00, 0, 4'h2, 4'h0, 0, 1, 8'd9, 1);
      add(0, 4'b0010, 32'h00000A00, 0, 4'h2, 4'h0, 0, 1, 8'd8, 0);
      add(0, 4'b0010, 32'h00000A00, 0, 4'h2, 4'h0, 0, 1, 8'd7, 1);
      add(0, 4'b0010, 32'h00000A00, 0, 4'h2, 4'h0, 0, 1, 8'd6, 0);
      add(0, 4'b0010, 32'h00000A00, 1, 4'h2, 4'h2, 1, 1, 8'd6, 0);
      add(0, 4'b0000, 32'h00000000, 0, 4'h0, 4'h0, 0, 0, 8'd6, 0);
      // abort outside RUN is ignored (IDLE idle, then IDLE with a request)
      add(0, 4'b0000, 32'h00000000, 1, 4'h0, 4'h0, 0, 0, 8'd6, 0);
      add(0, 4'b0001, 32'h00000002, 1, 4'h1, 4'h0, 0, 1, 8'd2, 0);
      add(0, 4'b0000, 32'h00000000, 0, 4'h1, 4'h0, 0, 1, 8'd1, 1);
      add(0, 4'b0000, 32'h00000000, 0, 4'h1, 4'h1, 0, 1, 8'd0, 0);
      add(0, 4'b0000, 32'h00000000, 0, 4'h0, 4'h0, 0, 0, 8'd0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         reset  = vecs[i].rst;
         req    = vecs[i].req;
         cnt_in = vecs[i].cnt;
         abort  = vecs[i].abort;
         @(posedge clk);
         #1;
         check_all($sformatf("v%0d", i), vecs[i].gnt, vecs[i].done, vecs[i].ab,
                   vecs[i].busy, vecs[i].tl, vecs[i].q);
      end

      // asynchronous reset in the middle of a 5-toggle burst (ptr is 1 here)
      req = 4'b0001; cnt_in = 32'h00000005; abort = 1'b0;
      @(posedge clk); #1;
      check_all("mid.grant", 4'h1, 4'h0, 0, 1, 8'd5, 0);
      @(posedge clk); #1;
      check_all("mid.t1", 4'h1, 4'h0, 0, 1, 8'd4, 1);
      @(posedge clk); #1;
      check_all("mid.t2", 4'h1, 4'h0, 0, 1, 8'd3, 0);
      @(posedge clk); #1;
      check_all("mid.t3", 4'h1, 4'h0, 0, 1, 8'd2, 1);
      #2;
      reset = 1'b1;
      #1;
      check_all("mid.async", 4'h0, 4'h0, 0, 0, 8'd0, 0);
      req = 4'b1111; cnt_in = 32'h01010101;
      @(posedge clk); #1;
      check_all("mid.held", 4'h0, 4'h0, 0, 0, 8'd0, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      check_all("mid.regrant", 4'h1, 4'h0, 0, 1, 8'd1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
